// File: rtl/serial_add_sequencer.sv
// Multi-cycle adder/subtractor that pushes a WORD_W operation through one SLICE_W adder,
// one slice per clock, with a valid/ready handshake on both the request and result sides.
module serial_add_sequencer #(
    parameter int WORD_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              sub,
    input  logic              cin,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] result,
    output logic              carry_out,
    output logic              overflow,
    output logic              busy
);

    localparam int N     = WORD_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               carry_reg;
    logic [WORD_W-1:0]  a_reg;
    logic [WORD_W-1:0]  b_reg;
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;

    assign start_ready = (state == IDLE) && rst_n;
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

    // Select the operand slices addressed by the counter and feed the single adder slice.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_slice = a_reg[i*SLICE_W +: SLICE_W];
                b_slice = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
        {slice_carry, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                                 + {{SLICE_W{1'b0}}, carry_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= sub ? ~op_b : op_b;
                        carry_reg <= sub ? 1'b1 : cin;
                        cnt       <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            result[i*SLICE_W +: SLICE_W] <= slice_sum;
                        end
                    end
                    carry_reg <= slice_carry;
                    // The final slice holds the word MSB, so flags can be taken straight off the adder.
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        carry_out <= slice_carry;
                        overflow  <= (a_reg[WORD_W-1] == b_reg[WORD_W-1])
                                  && (slice_sum[SLICE_W-1] != a_reg[WORD_W-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed-vector bench for serial_add_sequencer; a driver queues expected results and a
// monitor checks each result (and its latency) as res_valid rises.
module tb_serial_add_sequencer;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    serial_add_sequencer #(.WORD_W(32), .SLICE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Present one operation, queue its expected outcome, then scramble the operand inputs.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic ci,
                                 input logic [31:0] e_res, input logic e_c, input logic e_o);
        int   n;
        exp_t e;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = ci; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            checkOutput("accept_timeout", 64'(start_ready), 64'd1);
            start_valid = 1'b0;
        end else begin
            e.res = e_res; e.c = e_c; e.o = e_o; e.acc = cycle + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            op_a = $urandom; op_b = $urandom;
            sub = 1'($urandom); cin = 1'($urandom);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || res_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 64'(busy || res_valid), 64'd0);
    endtask

    // Monitor: every rising res_valid must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_res_valid", 64'(res_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result",    64'(result),    64'(e.res));
                    checkOutput("carry_out", 64'(carry_out), 64'(e.c));
                    checkOutput("overflow",  64'(overflow),  64'(e.o));
                    checkOutput("latency",   64'(cycle - e.acc), 64'd4);
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        exp_t e;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy",        64'(busy),        64'd0);
        checkOutput("reset_res_valid",   64'(res_valid),   64'd0);
        checkOutput("reset_result",      64'(result),      64'd0);
        checkOutput("reset_start_ready", 64'(start_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_start_ready", 64'(start_ready), 64'd1);

        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0); waitIdle();
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0); waitIdle();
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1); waitIdle();
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1); waitIdle();
        applyStimulus(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0); waitIdle();

        // Result back-pressure while a new request is already waiting.
        res_ready = 1'b0;
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_res_valid_rise", 64'(res_valid), 64'd1);
        op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; sub = 1'b0; cin = 1'b1; start_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_result",      64'(result),      64'h2345_6789);
            checkOutput("stall_carry",       64'(carry_out),   64'd0);
            checkOutput("stall_res_valid",   64'(res_valid),   64'd1);
            checkOutput("stall_start_ready", 64'(start_ready), 64'd0);
        end
        res_ready = 1'b1;
        e.res = 32'h0000_0000; e.c = 1'b1; e.o = 1'b0; e.acc = cycle + 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("handshake_res_valid",   64'(res_valid),   64'd0);
        checkOutput("handshake_start_ready", 64'(start_ready), 64'd1);
        checkOutput("handshake_result_kept", 64'(result),      64'h2345_6789);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        checkOutput("next_accept_busy", 64'(busy), 64'd1);
        waitIdle();

        // Reset two cycles into CALC aborts the operation without any result pulse.
        @(negedge clk);
        op_a = 32'h0F0F_0F0F; op_b = 32'h0101_0101; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
        checkOutput("abort_pre_ready", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy",        64'(busy),        64'd0);
        checkOutput("abort_res_valid",   64'(res_valid),   64'd0);
        checkOutput("abort_result",      64'(result),      64'd0);
        checkOutput("abort_carry",       64'(carry_out),   64'd0);
        checkOutput("abort_overflow",    64'(overflow),    64'd0);
        checkOutput("abort_start_ready", 64'(start_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_release_ready", 64'(start_ready), 64'd1);
        repeat (8) @(negedge clk);

        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0); waitIdle();

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
